// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline constants: stall-counter width/saturation and the payload
// widths of the concrete IF/ID/EXE/MEM/WB stage registers.
package pipe_stage_reg_pkg;

    localparam int STALL_CNT_W = 32;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

    // Concatenated payload widths carried between the concrete stages.
    localparam int IF_ID_PAYLOAD_W   = 64;
    localparam int ID_EXE_PAYLOAD_W  = 150;
    localparam int EXE_MEM_PAYLOAD_W = 76;
    localparam int MEM_WB_PAYLOAD_W  = 70;

    function automatic logic [STALL_CNT_W-1:0] stall_sat_inc(
        input logic [STALL_CNT_W-1:0] cnt
    );
        return (cnt == STALL_CNT_MAX) ? cnt : cnt + STALL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic valid/allowin pipeline stage register with flush and a saturating
// stall counter. Defining PIPE_STAGE_SKID_BUF_EN adds a 1-entry skid buffer.
//
// Handshake: an upstream transfer happens in a cycle where in_valid && allowin
// (and no flush); a downstream transfer where out_valid && ds_allowin. Both are
// evaluated in the same cycle and take effect on the next rising edge.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   ready_go,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   allowin,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    input  logic                   ds_allowin,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic                   head_valid_q, head_valid_d;
    logic [DATA_W-1:0]      head_data_q, head_data_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   up_xfer;
    logic                   ds_xfer;
    logic                   stall_cycle;

    assign out_valid   = head_valid_q && ready_go;
    assign out_data    = head_data_q;
    assign stall_cnt   = stall_cnt_q;
    assign ds_xfer     = out_valid && ds_allowin;
    // A flush cycle accepts nothing: the presented entry is dropped.
    assign up_xfer     = in_valid && allowin && !flush;
    assign stall_cycle = out_valid && !ds_allowin && !flush;

`ifdef PIPE_STAGE_SKID_BUF_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    // Registered allowin: no combinational path from ds_allowin or ready_go.
    assign allowin = !skid_valid_q;

    always_comb begin
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (ds_xfer && skid_valid_q) begin
            head_valid_d = 1'b1;
            head_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (ds_xfer || !head_valid_q) begin
            // Head is free this cycle and skid is empty: load straight into head.
            head_valid_d = up_xfer;
            if (up_xfer) begin
                head_data_d = in_data;
            end
        end else if (up_xfer) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= RESET_DATA;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    assign allowin = !head_valid_q || (ready_go && ds_allowin);

    always_comb begin
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        if (flush) begin
            head_valid_d = 1'b0;
        end else if (allowin) begin
            head_valid_d = in_valid;
            if (up_xfer) begin
                head_data_d = in_data;
            end
        end
    end
`endif

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_cycle) begin
            stall_cnt_d = stall_sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_valid_q <= 1'b0;
            head_data_q  <= RESET_DATA;
            stall_cnt_q  <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule
